// File: rtl/entities_line_renderer_if.sv
// ----------------------------------------------------------------------------
// entities_line_renderer_if
// Bundles the line-renderer's control, entity-RAM and pixel-read signals.
//   line_start       : one-cycle pulse, swap buffers and build line line_y
//   line_y           : board row to build (sampled with line_start)
//   entities_number  : valid entity list length (sampled with line_start)
//   address_read_ent : entity RAM read address
//   data_read_ent    : entity RAM read data {code[2:0], y[8:0], x[8:0]}
//   pixel_x          : front-buffer read column
//   pixel_type       : sprite code at pixel_x (registered)
//   busy             : back buffer is being built
//   overrun          : sticky, a line_start arrived while busy
// slave  : the renderer side
// master : the side that drives line control, the RAM data and pixel_x
// ----------------------------------------------------------------------------
interface entities_line_renderer_if;
    logic        line_start;
    logic [8:0]  line_y;
    logic [7:0]  entities_number;
    logic [7:0]  address_read_ent;
    logic [20:0] data_read_ent;
    logic [8:0]  pixel_x;
    logic [2:0]  pixel_type;
    logic        busy;
    logic        overrun;

    modport slave (
        input  line_start, line_y, entities_number, data_read_ent, pixel_x,
        output address_read_ent, pixel_type, busy, overrun
    );

    modport master (
        output line_start, line_y, entities_number, data_read_ent, pixel_x,
        input  address_read_ent, pixel_type, busy, overrun
    );
endinterface

// File: rtl/entities_line_renderer.sv
// ----------------------------------------------------------------------------
// entities_line_renderer
// Builds one display line at a time into a double-buffered line buffer by
// scanning the entity list and painting each 48x48 sprite that crosses the
// requested row. The front bank is read pixel by pixel while the back bank
// is built for the next line.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : entities_line_renderer_if.slave (line control, entity RAM read,
//           pixel read, busy/overrun status)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for line_start
// CLEAR  | writing CLEAR_CODE to every back-buffer cell, one per cycle
// FETCH  | issue entity RAM address idx
// WAIT   | RAM read latency
// TEST   | does entity idx cross row ly
// SPAN   | paint the sprite's 48 columns (clipped to the board)
// NEXT   | advance to the next entity or finish
// DONE   | drop busy
// ----------------------------------------------------------------------------
module entities_line_renderer #(
    parameter int         BOARD_PX   = 480,
    parameter int         SPRITE     = 48,
    parameter logic [2:0] CLEAR_CODE = 3'b000
) (
    input logic                     clk,
    input logic                     rst_n,
    entities_line_renderer_if.slave bus
);

    localparam logic [8:0] BOARD_W   = 9'(BOARD_PX);
    localparam logic [8:0] SPRITE_W  = 9'(SPRITE);
    localparam logic [8:0] LAST_CELL = 9'(BOARD_PX - 1);
    localparam logic [8:0] SPR_LAST  = 9'(SPRITE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_TEST, S_SPAN, S_NEXT, S_DONE
    } state_t;

    state_t     state, state_n;
    logic       front_sel, front_sel_n;
    logic       busy_q, busy_n;
    logic       overrun_q, overrun_n;
    logic [8:0] ly, ly_n;
    logic [7:0] n_q, n_n;
    logic [7:0] idx, idx_n;
    logic [8:0] cnt, cnt_n;
    logic [8:0] ent_x, ent_x_n;
    logic [2:0] ent_code, ent_code_n;
    logic [7:0] addr_q, addr_n;
    logic [2:0] pix_q;

    logic       wr_en;
    logic [8:0] wr_addr;
    logic [2:0] wr_data;
    logic [8:0] px;
    logic [8:0] dy;
    logic [7:0] idx_inc;

    // bank0 is front when front_sel=0; the other bank is always the back.
    logic [2:0] bank0 [BOARD_PX];
    logic [2:0] bank1 [BOARD_PX];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            front_sel <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            ly        <= '0;
            n_q       <= '0;
            idx       <= '0;
            cnt       <= '0;
            ent_x     <= '0;
            ent_code  <= '0;
            addr_q    <= '0;
        end else begin
            state     <= state_n;
            front_sel <= front_sel_n;
            busy_q    <= busy_n;
            overrun_q <= overrun_n;
            ly        <= ly_n;
            n_q       <= n_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            ent_x     <= ent_x_n;
            ent_code  <= ent_code_n;
            addr_q    <= addr_n;
        end
    end

    always_comb begin
        state_n     = state;
        front_sel_n = front_sel;
        busy_n      = busy_q;
        overrun_n   = overrun_q;
        ly_n        = ly;
        n_n         = n_q;
        idx_n       = idx;
        cnt_n       = cnt;
        ent_x_n     = ent_x;
        ent_code_n  = ent_code;
        addr_n      = addr_q;
        wr_en       = 1'b0;
        wr_addr     = cnt;
        wr_data     = CLEAR_CODE;
        // 9-bit wrap gives correct clipping for sprites above/left of board.
        px          = ent_x + cnt;
        dy          = ly - bus.data_read_ent[17:9];
        idx_inc     = idx + 8'd1;

        case (state)
            S_IDLE: ;
            S_CLEAR: begin
                wr_en = 1'b1;
                if (cnt == 9'd0) begin
                    idx_n   = '0;
                    state_n = (n_q == 8'd0) ? S_DONE : S_FETCH;
                end else begin
                    cnt_n = cnt - 9'd1;
                end
            end
            S_FETCH: begin
                addr_n  = idx;
                state_n = S_WAIT;
            end
            S_WAIT: state_n = S_TEST;
            S_TEST: begin
                if (dy < SPRITE_W) begin
                    ent_x_n    = bus.data_read_ent[8:0];
                    ent_code_n = bus.data_read_ent[20:18];
                    cnt_n      = SPR_LAST;
                    state_n    = S_SPAN;
                end else begin
                    state_n = S_NEXT;
                end
            end
            S_SPAN: begin
                // Columns are painted right to left; all carry the same code.
                wr_addr = px;
                wr_data = ent_code;
                wr_en   = (px < BOARD_W);
                if (cnt == 9'd0) state_n = S_NEXT;
                else             cnt_n   = cnt - 9'd1;
            end
            S_NEXT: begin
                idx_n   = idx_inc;
                state_n = (idx_inc == n_q) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // A new line always wins; a build still in progress is abandoned and
        // its write this cycle is dropped so the outgoing back bank, now the
        // front, is not touched after the swap.
        if (bus.line_start) begin
            front_sel_n = ~front_sel;
            ly_n        = bus.line_y;
            n_n         = bus.entities_number;
            cnt_n       = LAST_CELL;
            busy_n      = 1'b1;
            state_n     = S_CLEAR;
            wr_en       = 1'b0;
            if (busy_q && state != S_DONE) overrun_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front_sel) bank0[wr_addr] <= wr_data;
            else           bank1[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
        end else if (bus.pixel_x < BOARD_W) begin
            pix_q <= front_sel ? bank1[bus.pixel_x] : bank0[bus.pixel_x];
        end else begin
            pix_q <= CLEAR_CODE;
        end
    end

    assign bus.address_read_ent = addr_q;
    assign bus.pixel_type       = pix_q;
    assign bus.busy             = busy_q;
    assign bus.overrun          = overrun_q;

endmodule

// File: tb/tb_entities_line_renderer.sv
// ----------------------------------------------------------------------------
// tb_entities_line_renderer
// Directed bench for entities_line_renderer: a 1-cycle-latency entity RAM
// model, line builds with hand-computed expected lines, overrun and
// asynchronous reset behaviour.
// ----------------------------------------------------------------------------
module tb_entities_line_renderer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    entities_line_renderer_if ifc ();

    entities_line_renderer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    logic [20:0] ent_mem [256];
    logic [2:0]  exp_line [480];

    always @(posedge clk) ifc.data_read_ent <= ent_mem[ifc.address_read_ent];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] ent(input logic [2:0] c, input logic [8:0] y, input logic [8:0] x);
        return {c, y, x};
    endfunction

    task automatic pulse(input logic [8:0] ly, input logic [7:0] n);
        @(negedge clk);
        ifc.line_y          = ly;
        ifc.entities_number = n;
        ifc.line_start      = 1'b1;
        @(negedge clk);
        ifc.line_start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (ifc.busy === 1'b1 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_busy_end"}, 32'(ifc.busy), 0);
    endtask

    // Build a line into the back bank, then swap it to the front with an
    // empty build so it can be read.
    task automatic build(input logic [8:0] ly, input logic [7:0] n, input string tag);
        pulse(ly, n);
        wait_idle(tag);
        pulse(9'd0, 8'd0);
        wait_idle({tag, "_swap"});
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 480; i++) exp_line[i] = 3'd0;
    endtask

    task automatic fill_exp(input int lo, input int hi, input logic [2:0] c);
        for (int i = lo; i <= hi; i++) exp_line[i] = c;
    endtask

    task automatic compare_line(input string tag);
        int bad   = 0;
        int first = -1;
        for (int x = 0; x < 480; x++) begin
            @(negedge clk);
            ifc.pixel_x = 9'(x);
            @(negedge clk);
            if (ifc.pixel_type !== exp_line[x]) begin
                bad++;
                if (first < 0) first = x;
            end
        end
        if (bad != 0) $display("  %s: first differing pixel %0d", tag, first);
        check({tag, "_bad_pixels"}, 32'(bad), 0);
    endtask

    initial begin
        int len;
        ifc.line_start      = 1'b0;
        ifc.line_y          = '0;
        ifc.entities_number = '0;
        ifc.pixel_x         = '0;
        for (int i = 0; i < 256; i++) ent_mem[i] = '0;

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(ifc.busy), 0);
        check("reset_overrun", 32'(ifc.overrun), 0);
        check("reset_pixel", 32'(ifc.pixel_type), 0);
        check("reset_addr", 32'(ifc.address_read_ent), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single sprite at the origin.
        ent_mem[0] = ent(3'd3, 9'd0, 9'd0);
        build(9'd0, 8'd1, "single");
        clear_exp(); fill_exp(0, 47, 3'd3);
        compare_line("single");
        @(negedge clk); ifc.pixel_x = 9'd500;
        @(negedge clk);
        check("offboard_px500", 32'(ifc.pixel_type), 0);

        // Overlap: later entry overwrites earlier one.
        ent_mem[0] = ent(3'd1, 9'd0, 9'd0);
        ent_mem[1] = ent(3'd2, 9'd10, 9'd24);
        build(9'd20, 8'd2, "overlap20");
        clear_exp(); fill_exp(0, 23, 3'd1); fill_exp(24, 71, 3'd2);
        compare_line("overlap20");
        build(9'd5, 8'd2, "overlap5");
        clear_exp(); fill_exp(0, 47, 3'd1);
        compare_line("overlap5");
        check("no_overrun_normal", 32'(ifc.overrun), 0);

        // Vertical edges: last row hit, one past, one before.
        ent_mem[0] = ent(3'd4, 9'd100, 9'd96);
        build(9'd147, 8'd1, "vedge147");
        clear_exp(); fill_exp(96, 143, 3'd4);
        compare_line("vedge147");
        build(9'd148, 8'd1, "vmiss148");
        clear_exp();
        compare_line("vmiss148");
        build(9'd99, 8'd1, "vmiss99");
        clear_exp();
        compare_line("vmiss99");

        // Wrap: x=-12 shows 36 columns; y=-32 still covers row 0.
        ent_mem[0] = ent(3'd5, 9'd0, 9'd500);
        build(9'd0, 8'd1, "xwrap");
        clear_exp(); fill_exp(0, 35, 3'd5);
        compare_line("xwrap");
        ent_mem[0] = ent(3'd5, 9'd480, 9'd0);
        build(9'd0, 8'd1, "ywrap");
        clear_exp(); fill_exp(0, 47, 3'd5);
        compare_line("ywrap");

        // Overrun: 100 hitting entries, restarted after 1000 cycles.
        for (int i = 0; i < 100; i++) ent_mem[i] = ent(3'(i % 7 + 1), 9'd200, 9'(i * 4));
        pulse(9'd200, 8'd100);
        repeat (1000) @(negedge clk);
        check("overrun_before_restart", 32'(ifc.overrun), 0);
        pulse(9'd200, 8'd100);
        check("overrun_set", 32'(ifc.overrun), 1);
        repeat (4000) @(negedge clk);
        check("rebuild_still_busy", 32'(ifc.busy), 1);
        wait_idle("rebuild");
        check("overrun_sticky", 32'(ifc.overrun), 1);
        pulse(9'd0, 8'd0);
        wait_idle("rebuild_swap");
        clear_exp();
        for (int i = 0; i < 100; i++) fill_exp(i * 4, i * 4 + 47, 3'(i % 7 + 1));
        compare_line("painter");
        check("overrun_after_read", 32'(ifc.overrun), 1);

        // Asynchronous reset in the middle of a sprite span.
        @(negedge clk); ifc.pixel_x = 9'd0;
        @(negedge clk);
        check("pre_reset_pixel", 32'(ifc.pixel_type), 1);
        pulse(9'd200, 8'd100);
        repeat (500) @(negedge clk);
        check("pre_reset_busy", 32'(ifc.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(ifc.busy), 0);
        check("async_rst_pixel", 32'(ifc.pixel_type), 0);
        check("async_rst_overrun", 32'(ifc.overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty build: busy window counted from the line_start cycle.
        ifc.line_y          = 9'd0;
        ifc.entities_number = 8'd0;
        ifc.line_start      = 1'b1;
        @(negedge clk);
        ifc.line_start      = 1'b0;
        len = 1;
        while (ifc.busy === 1'b1 && len < 2000) begin
            len++;
            @(negedge clk);
        end
        check("busy_len_n0", 32'(len), 482);
        pulse(9'd0, 8'd0);
        wait_idle("post_reset_swap");
        clear_exp();
        compare_line("post_reset_clear");
        check("overrun_after_reset", 32'(ifc.overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
